// File: rtl/byte_packer_pkg.sv
// Shared types and constants for the byte-to-word packer.
package byte_packer_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_t;

  typedef struct packed {
    logic              partial;
    logic [WORD_W-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out handshake bundle; slave is the packer, master the surrounding logic.
interface byte_packer_if;
  import byte_packer_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              inv;
  logic              flush;
  logic [WORD_W-1:0] word_out;
  logic              word_partial;
  logic              word_valid;
  logic              word_ready;

  modport slave (
    input  byte_in, byte_valid, inv, flush, word_ready,
    output byte_ready, word_out, word_partial, word_valid
  );

  modport master (
    output byte_in, byte_valid, inv, flush, word_ready,
    input  byte_ready, word_out, word_partial, word_valid
  );

endinterface

// File: rtl/byte_packer_fifo.sv
// Synchronous FIFO, DEPTH entries of WIDTH bits; head reads as zero while empty.
module byte_packer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rest_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage is left unreset; the empty flag masks the head, so stale words never leak out.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/byte_packer.sv
// Pairs bytes into 16-bit words (byte order chosen at the first byte) and queues them.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rest_n,
  byte_packer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            r_state;
  logic [BYTE_W-1:0] r_hold;
  logic              r_inv_q;

  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [BYTE_W-1:0] w_second;
  fifo_entry_t       w_push_entry;
  fifo_entry_t       w_head;

  // Refusing a first byte when full guarantees its partner always finds a slot.
  assign bus.byte_ready = !bus.flush && (w_count < CNT_W'(DEPTH));
  assign w_accept       = bus.byte_valid && bus.byte_ready;
  assign w_pop          = !w_empty && bus.word_ready;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_second             = w_accept ? bus.byte_in : PAD_BYTE;
    w_push               = (r_state == ST_HALF) && (w_accept || (bus.flush && !w_full));
    w_push_entry.partial = !w_accept;
    w_push_entry.word    = r_inv_q ? {w_second, r_hold} : {r_hold, w_second};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_state <= ST_EMPTY;
      r_hold  <= '0;
      r_inv_q <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_hold  <= bus.byte_in;
            r_inv_q <= bus.inv;
            r_state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (w_push) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  byte_packer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rest_n  (rest_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.word_out     = w_head.word;
  assign bus.word_partial = w_head.partial;
  assign bus.word_valid   = !w_empty;

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: expected words queued on byte accept, compared on pop.
module tb_byte_packer;
  import byte_packer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rest_n;
  int   cyc = 0;

  byte_packer_if bp_if();

  byte_packer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rest_n (rest_n),
    .bus    (bp_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [15:0] w;
    logic        p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference packing state, driven only by what the bench sends.
  bit         m_half = 1'b0;
  logic [7:0] m_first;
  logic       m_inv;

  function automatic void model_accept(input logic [7:0] b, input logic iv);
    if (!m_half) begin
      m_first = b;
      m_inv   = iv;
      m_half  = 1'b1;
    end else begin
      sb.push_back(m_inv ? {b, m_first, 1'b0} : {m_first, b, 1'b0});
      m_half = 1'b0;
    end
  endfunction

  function automatic void model_flush();
    if (m_half) begin
      sb.push_back(m_inv ? {8'h00, m_first, 1'b1} : {m_first, 8'h00, 1'b1});
      m_half = 1'b0;
    end
  endfunction

  // Scoreboard: every pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (rest_n && bp_if.word_valid && bp_if.word_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got word=%h partial=%b want no word", bp_if.word_out, bp_if.word_partial);
      end else begin
        mon_e = sb.pop_front();
        if (bp_if.word_out !== mon_e.w || bp_if.word_partial !== mon_e.p) begin
          errors++;
          $display("FAIL pop_word got %h/%b want %h/%b", bp_if.word_out, bp_if.word_partial, mon_e.w, mon_e.p);
        end
      end
    end
  end

  // Offer one byte and wait (bounded) for it to be accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic iv);
    bit done;
    done = 1'b0;
    bp_if.byte_in    = b;
    bp_if.inv        = iv;
    bp_if.byte_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (bp_if.byte_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bp_if.byte_valid = 1'b0;
    if (done) model_accept(b, iv);
    else begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout byte=%h got no accept want accept", b);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bp_if.word_ready = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!bp_if.word_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL drain got valid=%b left=%0d want valid=0 left=0", bp_if.word_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rest_n = 1'b0;
    #3;
    checks++;
    if (bp_if.word_valid !== 1'b0 || bp_if.word_out !== 16'h0000 || bp_if.word_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b w=%h p=%b want 0/0000/0", bp_if.word_valid, bp_if.word_out, bp_if.word_partial);
    end
    checks++;
    if (bp_if.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_byte_ready got %b want 1", bp_if.byte_ready);
    end
    bp_if.flush = 1'b1;
    #1;
    checks++;
    if (bp_if.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_flush got %b want 0", bp_if.byte_ready);
    end
    bp_if.flush = 1'b0;
    @(posedge clk);
    #1;
    rest_n = 1'b1;
  endtask

  task automatic test_basic();
    bp_if.word_ready = 1'b1;
    send_byte(8'hAB, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_half_valid got %b want 0", bp_if.word_valid);
    end
    @(posedge clk);
    #1;
    send_byte(8'hCD, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b1 || bp_if.word_out !== 16'hABCD || bp_if.word_partial !== 1'b0) begin
      errors++;
      $display("FAIL basic_word got v=%b w=%h p=%b want 1/abcd/0", bp_if.word_valid, bp_if.word_out, bp_if.word_partial);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle got valid=%b want 0", bp_if.word_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_inv();
    bp_if.word_ready = 1'b1;
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b1 || bp_if.word_out !== 16'hCDAB) begin
      errors++;
      $display("FAIL inv_word got v=%b w=%h want 1/cdab", bp_if.word_valid, bp_if.word_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush(input logic iv, input logic [15:0] want);
    bp_if.word_ready = 1'b1;
    send_byte(8'h12, iv);
    bp_if.flush = 1'b1;
    model_flush();
    @(negedge clk);
    checks++;
    if (bp_if.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b want 0", bp_if.byte_ready);
    end
    @(posedge clk);
    #1;
    bp_if.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b1 || bp_if.word_out !== want || bp_if.word_partial !== 1'b1) begin
      errors++;
      $display("FAIL flush_word got v=%b w=%h p=%b want 1/%h/1", bp_if.word_valid, bp_if.word_out, bp_if.word_partial, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_empty();
    bp_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bp_if.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got valid=%b want 0", bp_if.word_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    bp_if.word_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    checks++;
    if (bp_if.byte_ready !== 1'b0 || bp_if.word_valid !== 1'b1 || bp_if.word_out !== 16'h1011) begin
      errors++;
      $display("FAIL full_state got rdy=%b v=%b w=%h want 0/1/1011", bp_if.byte_ready, bp_if.word_valid, bp_if.word_out);
    end
    @(posedge clk);
    #1;
    bp_if.byte_in    = 8'hEE;
    bp_if.byte_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bp_if.byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_refuse cycle=%0d got rdy=%b want 0", k, bp_if.byte_ready);
      end
      @(posedge clk);
      #1;
    end
    bp_if.byte_valid = 1'b0;
    bp_if.word_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bp_if.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_prepop_ready got %b want 0", bp_if.byte_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bp_if.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_postpop_ready got %b want 1", bp_if.byte_ready);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_flush_into_last_slot();
    bp_if.word_ready = 1'b0;
    for (int i = 0; i < 2 * (DEPTH - 1); i++) send_byte(8'h30 + 8'(i), 1'b0);
    send_byte(8'h3F, 1'b1);
    bp_if.flush = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b1 || bp_if.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_last_hold got v=%b rdy=%b want 1/0", bp_if.word_valid, bp_if.byte_ready);
    end
    @(posedge clk);
    #1;
    bp_if.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bp_if.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_last_full got rdy=%b want 0", bp_if.byte_ready);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    bp_if.word_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'(i / 2 % 2));
    checks++;
    if (cyc - t0 != 8) begin
      errors++;
      $display("FAIL b2b_cycles got %0d want 8", cyc - t0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bp_if.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    #2;
    rest_n = 1'b0;
    #1;
    checks++;
    if (bp_if.word_valid !== 1'b0 || bp_if.word_out !== 16'h0000 || bp_if.word_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got v=%b w=%h p=%b want 0/0000/0", bp_if.word_valid, bp_if.word_out, bp_if.word_partial);
    end
    sb.delete();
    m_half = 1'b0;
    @(posedge clk);
    #1;
    rest_n = 1'b1;
    bp_if.word_ready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_if.word_valid !== 1'b1 || bp_if.word_out !== 16'h0102 || bp_if.word_partial !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover got v=%b w=%h p=%b want 1/0102/0", bp_if.word_valid, bp_if.word_out, bp_if.word_partial);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bp_if.byte_in    = 8'h00;
    bp_if.byte_valid = 1'b0;
    bp_if.inv        = 1'b0;
    bp_if.flush      = 1'b0;
    bp_if.word_ready = 1'b0;
    test_reset();
    test_basic();
    test_inv();
    test_flush(1'b0, 16'h1200);
    test_flush(1'b1, 16'h0012);
    test_flush_empty();
    test_full();
    test_flush_into_last_slot();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
# byte_packer

Byte-to-word packer: accepts an 8-bit byte stream over a valid/ready handshake and assembles pairs of bytes into 16-bit words with selectable byte order (`inv`). Completed words are buffered in a small FIFO and presented on a 16-bit valid/ready output. It sits upstream of the 16-bit swap/hold register as the producer side of the same word path, rebuilding words from byte-serial sources.

## Interface
- `DEPTH`, default 4: output FIFO depth in words; power of two, minimum 2.
- `clk`  in  1: single clock, rising edge.
- `rest_n`  in  1: asynchronous, active-low reset.
- `byte_in`  in  8: input byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: packer accepts a byte this cycle.
- `inv`  in  1: byte order for the word being started. 0: first byte to [15:8]. 1: first byte to [7:0].
- `flush`  in  1: level; closes a half-built word by zero-padding it.
- `word_out`  out  16: FIFO head word.
- `word_partial`  out  1: head word was closed by flush (one byte is pad).
- `word_valid`  out  1: FIFO not empty.
- `word_ready`  in  1: consumer takes the head word.

## Operation
- Byte accept happens when `byte_valid && byte_ready`. Word pop happens when `word_valid && word_ready`.
- The FSM has two states:
  - EMPTY: no byte held. On accept, latch `byte_in` into the hold register and latch `inv` into `inv_q`. Go to HALF.
  - HALF: one byte held. On accept, build the word and push it to the FIFO. Go to EMPTY.
    - `inv_q`=0: word = {first, second}.
    - `inv_q`=1: word = {second, first}.
  - `inv` is sampled only on the first byte. Changes to `inv` in HALF are ignored.
- `byte_ready` = !`flush` && (count < DEPTH). It is combinational from registered count and `flush`.
  - A first byte is refused when the FIFO is full. This keeps a slot free for its partner.
- Flush:
  - HALF && `flush` && count < DEPTH: push the padded word with the missing byte = 8'h00, in the position the second byte would have taken. Set `word_partial`=1 for that entry. Go to EMPTY.
  - HALF && `flush` && FIFO full: stay in HALF and retry each cycle while `flush` stays high.
  - EMPTY && `flush`: no effect.
- Push and pop in the same cycle: count is unchanged and data order is preserved.
- Pop on the cycle count reaches DEPTH: `byte_ready` uses pre-pop count, so it stays low that cycle (no fall-through).
- FIFO order is strict first-in first-out. Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset mid-operation drops the held byte and all FIFO contents. There is no partial-word recovery.

## Timing
- Reset values: `word_out`=16'h0000, `word_partial`=0, `word_valid`=0, FSM=EMPTY, count=0. `byte_ready` follows its equation, so it is 1 unless `flush` is high.
- Latency: second byte accepted at edge N → `word_valid`=1 and `word_out` correct after edge N (registered FIFO, visible in cycle N+1).
- Flush latency: flush push at edge N → word visible in cycle N+1.
- `word_out`/`word_partial` stay stable while `word_valid`=1 and `word_ready`=0.
- Throughput: one byte per cycle in, one word per two cycles in steady state. No bubbles when `word_ready`=1.

## Structure
- Package `byte_packer_pkg` holds:
  - state enum {ST_EMPTY, ST_HALF};
  - `WORD_W`=16, `BYTE_W`=8;
  - `PAD_BYTE`=8'h00.
- Sub-module `byte_packer_fifo`: parameterised DEPTH × (WORD_W+1) synchronous FIFO with push/pop/full/empty/count. Same clock, same async active-low reset.
- Top level holds the FSM, hold register, `inv_q`, and word assembly.

## Test plan
- Bytes 8'hAB, 8'hCD with `inv`=0, `word_ready`=1 → one word 16'hABCD, `word_partial`=0, valid exactly one cycle after the second accept.
- Same bytes with `inv`=1 at the first byte, toggled to 0 before the second → 16'hCDAB.
- 8'h12 accepted, then `flush` pulsed one cycle → 16'h1200 with `word_partial`=1. With `inv`=1 → 16'h0012.
- `word_ready`=0, stream 2·DEPTH bytes:
  - After DEPTH words, `byte_ready`=0 and a first byte is refused.
  - Raise `word_ready` → words pop in order, `byte_ready` returns the cycle after the first pop.
- FIFO full + HALF + `flush` held → nothing pushed until a pop, then the padded word is pushed on the next edge.
- Assert `rest_n`=0 mid-word with 2 words queued → `word_valid`=0 immediately (async). After release, bytes 8'h01, 8'h02 → 16'h0102 with no stale data.
